// File: rtl/uvmt_cv32e40x_pkg.sv
// Shared types for the PMA/OBI tracker: PMA verdict, tracked entry, stability FSM states.
package uvmt_cv32e40x_pkg;

  localparam int unsigned OBI_TRACK_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic allow;
    logic main;
    logic bufferable;
    logic cacheable;
  } pma_status_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    pma_status_t status;
  } obi_track_entry_t;

  typedef enum logic {
    IDLE,
    WAIT_GNT
  } obi_track_state_e;

endpackage

// File: rtl/uvmt_cv32e40x_pma_obi_tracker_if.sv
// OBI bus plus same-cycle PMA verdict as observed by the tracker.
interface uvmt_cv32e40x_pma_obi_tracker_if;
  import uvmt_cv32e40x_pkg::*;

  logic        obi_req;
  logic        obi_gnt;
  logic [31:0] obi_addr;
  logic        obi_we;
  logic [1:0]  obi_memtype;
  logic        obi_rvalid;
  logic        obi_err;
  pma_status_t pma_status_i;

  modport master (
    output obi_req, obi_gnt, obi_addr, obi_we, obi_memtype,
           obi_rvalid, obi_err, pma_status_i
  );

  modport slave (
    input obi_req, obi_gnt, obi_addr, obi_we, obi_memtype,
          obi_rvalid, obi_err, pma_status_i
  );
endinterface

// File: rtl/uvmt_cv32e40x_obi_track_fifo.sv
// In-order FIFO of granted OBI transactions; push while full is only taken with a same-cycle pop.
module uvmt_cv32e40x_obi_track_fifo
  import uvmt_cv32e40x_pkg::*;
#(
  parameter int unsigned DEPTH = OBI_TRACK_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  obi_track_entry_t       din,
  output obi_track_entry_t       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  obi_track_entry_t mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  assign head = mem[rptr];

endmodule

// File: rtl/uvmt_cv32e40x_pma_obi_tracker.sv
// Pairs each OBI response with the PMA verdict captured at its grant and flags protocol/attribute violations.
module uvmt_cv32e40x_pma_obi_tracker
  import uvmt_cv32e40x_pkg::*;
#(
  parameter int unsigned DEPTH         = OBI_TRACK_DEPTH_DEFAULT,
  parameter bit          IS_INSTR_SIDE = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  uvmt_cv32e40x_pma_obi_tracker_if.slave bus,
  output logic                          rsp_valid,
  output logic [31:0]                   rsp_addr,
  output logic                          rsp_we,
  output pma_status_t                   rsp_status,
  output logic [$clog2(DEPTH):0]        outstanding,
  output logic                          req_unstable_err,
  output logic                          overflow_err,
  output logic                          underflow_err,
  output logic                          memtype_err,
  output logic                          deny_leak_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  obi_track_state_e state, state_nxt;
  obi_track_entry_t push_entry, head;
  logic [31:0]      latch_addr;
  logic             latch_we;
  logic             relatch;
  logic             unstable_set;
  logic             accept;
  logic             pop;
  logic             full;
  logic             unused_err;

  // obi_err travels on the bus for downstream consumers only
  assign unused_err = bus.obi_err;

  assign accept     = bus.obi_req && bus.obi_gnt;
  assign pop        = bus.obi_rvalid && (outstanding != '0);
  assign full       = (outstanding == FULL_CNT);
  assign push_entry = '{addr: bus.obi_addr, we: bus.obi_we, status: bus.pma_status_i};

  uvmt_cv32e40x_obi_track_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .count (outstanding)
  );

  assign rsp_valid  = pop;
  assign rsp_addr   = head.addr;
  assign rsp_we     = head.we;
  assign rsp_status = head.status;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (bus.obi_req && !bus.obi_gnt) state_nxt = WAIT_GNT;
      WAIT_GNT: if (!bus.obi_req || bus.obi_gnt) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // A changed address while still waiting is flagged but tracking continues with the new value
  always_comb begin
    relatch      = 1'b0;
    unstable_set = 1'b0;
    unique case (state)
      IDLE: relatch = bus.obi_req && !bus.obi_gnt;
      WAIT_GNT: begin
        if (!bus.obi_req) begin
          unstable_set = 1'b1;
        end else if (!bus.obi_gnt &&
                     ((bus.obi_addr != latch_addr) || (bus.obi_we != latch_we))) begin
          unstable_set = 1'b1;
          relatch      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_addr <= '0;
      latch_we   <= 1'b0;
    end else if (relatch) begin
      latch_addr <= bus.obi_addr;
      latch_we   <= bus.obi_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_unstable_err <= 1'b0;
      overflow_err     <= 1'b0;
      underflow_err    <= 1'b0;
      memtype_err      <= 1'b0;
      deny_leak_err    <= 1'b0;
    end else begin
      if (unstable_set)                               req_unstable_err <= 1'b1;
      if (accept && full && !pop)                     overflow_err     <= 1'b1;
      if (bus.obi_rvalid && (outstanding == '0))      underflow_err    <= 1'b1;
      if (accept && (bus.obi_memtype !=
          {bus.pma_status_i.cacheable, bus.pma_status_i.bufferable}))
                                                      memtype_err      <= 1'b1;
      if (accept && (!bus.pma_status_i.allow || (IS_INSTR_SIDE && bus.obi_we)))
                                                      deny_leak_err    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uvmt_cv32e40x_pma_obi_tracker.sv
// Directed bench for the PMA/OBI tracker: data-side and instruction-side instances share one bus.
module tb_uvmt_cv32e40x_pma_obi_tracker;
  import uvmt_cv32e40x_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  localparam pma_status_t ST_OK   = '{allow: 1'b1, main: 1'b1, bufferable: 1'b0, cacheable: 1'b0};
  localparam pma_status_t ST_BUF  = '{allow: 1'b1, main: 1'b1, bufferable: 1'b1, cacheable: 1'b0};
  localparam pma_status_t ST_DENY = '{allow: 1'b0, main: 1'b1, bufferable: 1'b0, cacheable: 1'b0};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uvmt_cv32e40x_pma_obi_tracker_if bus();

  logic          rsp_valid_d, rsp_we_d, unst_d, over_d, under_d, mem_d, deny_d;
  logic [31:0]   rsp_addr_d;
  pma_status_t   rsp_status_d;
  logic [CW-1:0] outst_d;
  logic          rsp_valid_i, rsp_we_i, unst_i, over_i, under_i, mem_i, deny_i;
  logic [31:0]   rsp_addr_i;
  pma_status_t   rsp_status_i;
  logic [CW-1:0] outst_i;

  uvmt_cv32e40x_pma_obi_tracker #(.DEPTH(DEPTH), .IS_INSTR_SIDE(1'b0)) u_data (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .rsp_valid(rsp_valid_d), .rsp_addr(rsp_addr_d), .rsp_we(rsp_we_d), .rsp_status(rsp_status_d),
    .outstanding(outst_d), .req_unstable_err(unst_d), .overflow_err(over_d),
    .underflow_err(under_d), .memtype_err(mem_d), .deny_leak_err(deny_d)
  );

  uvmt_cv32e40x_pma_obi_tracker #(.DEPTH(DEPTH), .IS_INSTR_SIDE(1'b1)) u_instr (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .rsp_valid(rsp_valid_i), .rsp_addr(rsp_addr_i), .rsp_we(rsp_we_i), .rsp_status(rsp_status_i),
    .outstanding(outst_i), .req_unstable_err(unst_i), .overflow_err(over_i),
    .underflow_err(under_i), .memtype_err(mem_i), .deny_leak_err(deny_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of granted transactions plus sticky flag bits
  obi_track_entry_t mq[$];
  bit          m_unst, m_over, m_under, m_mem, m_deny_d, m_deny_i;
  bit          pend;
  logic [31:0] pend_addr;
  logic        pend_we;
  bit          m_acc, m_pop, m_rsp;
  int          m_size;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      {m_unst, m_over, m_under, m_mem, m_deny_d, m_deny_i, pend} = '0;
      pend_addr = '0;
      pend_we   = 1'b0;
    end else begin
      m_size = mq.size();
      m_rsp  = bus.obi_rvalid && (m_size != 0);
      check("d_rsp_valid", 32'(rsp_valid_d), 32'(m_rsp));
      check("i_rsp_valid", 32'(rsp_valid_i), 32'(m_rsp));
      if (m_rsp) begin
        check("d_rsp_addr",   rsp_addr_d,          mq[0].addr);
        check("i_rsp_addr",   rsp_addr_i,          mq[0].addr);
        check("d_rsp_we",     32'(rsp_we_d),       32'(mq[0].we));
        check("i_rsp_we",     32'(rsp_we_i),       32'(mq[0].we));
        check("d_rsp_status", 32'(rsp_status_d),   32'(mq[0].status));
        check("i_rsp_status", 32'(rsp_status_i),   32'(mq[0].status));
      end
      check("d_outstanding", 32'(outst_d), 32'(m_size));
      check("i_outstanding", 32'(outst_i), 32'(m_size));
      check("d_unstable",  32'(unst_d),  32'(m_unst));
      check("i_unstable",  32'(unst_i),  32'(m_unst));
      check("d_overflow",  32'(over_d),  32'(m_over));
      check("i_overflow",  32'(over_i),  32'(m_over));
      check("d_underflow", 32'(under_d), 32'(m_under));
      check("i_underflow", 32'(under_i), 32'(m_under));
      check("d_memtype",   32'(mem_d),   32'(m_mem));
      check("i_memtype",   32'(mem_i),   32'(m_mem));
      check("d_deny",      32'(deny_d),  32'(m_deny_d));
      check("i_deny",      32'(deny_i),  32'(m_deny_i));

      m_acc = bus.obi_req && bus.obi_gnt;
      m_pop = m_rsp;
      if (bus.obi_rvalid && (m_size == 0)) m_under = 1'b1;
      if (pend && (!bus.obi_req || (!bus.obi_gnt &&
          ((bus.obi_addr != pend_addr) || (bus.obi_we != pend_we))))) m_unst = 1'b1;
      pend = bus.obi_req && !bus.obi_gnt;
      if (pend) begin
        pend_addr = bus.obi_addr;
        pend_we   = bus.obi_we;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_acc) begin
        if (bus.obi_memtype[0] != bus.pma_status_i.bufferable ||
            bus.obi_memtype[1] != bus.pma_status_i.cacheable) m_mem = 1'b1;
        if (!bus.pma_status_i.allow) begin
          m_deny_d = 1'b1;
          m_deny_i = 1'b1;
        end
        if (bus.obi_we) m_deny_i = 1'b1;
        if ((m_size == DEPTH) && !m_pop) m_over = 1'b1;
        else mq.push_back('{addr: bus.obi_addr, we: bus.obi_we, status: bus.pma_status_i});
      end
    end
  end

  task automatic step(input logic req, input logic gnt, input logic [31:0] addr, input logic we,
                      input logic [1:0] mt, input logic rv, input pma_status_t st);
    @(posedge clk); #1;
    bus.obi_req      = req;
    bus.obi_gnt      = gnt;
    bus.obi_addr     = addr;
    bus.obi_we       = we;
    bus.obi_memtype  = mt;
    bus.obi_rvalid   = rv;
    bus.obi_err      = 1'b0;
    bus.pma_status_i = st;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, ST_OK);
  endtask

  task automatic grant(input logic [31:0] addr);
    step(1'b1, 1'b1, addr, 1'b0, 2'b00, 1'b0, ST_OK);
  endtask

  task automatic respond();
    step(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b1, ST_OK);
  endtask

  logic [31:0] drain_exp [4];

  initial begin
    bus.obi_req = 1'b0; bus.obi_gnt = 1'b0; bus.obi_addr = '0; bus.obi_we = 1'b0;
    bus.obi_memtype = 2'b00; bus.obi_rvalid = 1'b0; bus.obi_err = 1'b0; bus.pma_status_i = ST_OK;
    @(negedge clk);
    check("reset_outstanding", 32'(outst_d), 32'd0);
    check("reset_flags", 32'({unst_d, over_d, under_d, mem_d, deny_d}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Back-to-back grants, responses on cycles 3 and 4
    grant(32'h0000_1000);
    check("t1_out_c1", 32'(outst_d), 32'd0);
    grant(32'h0000_2000);
    check("t1_out_c2", 32'(outst_d), 32'd1);
    respond();
    check("t1_out_c3", 32'(outst_d), 32'd2);
    check("t1_addr_c3", rsp_addr_d, 32'h0000_1000);
    respond();
    check("t1_out_c4", 32'(outst_d), 32'd1);
    check("t1_addr_c4", rsp_addr_d, 32'h0000_2000);
    idle();
    check("t1_out_c5", 32'(outst_d), 32'd0);

    // Address changes while waiting for grant
    step(1'b1, 1'b0, 32'h0000_3000, 1'b0, 2'b00, 1'b0, ST_OK);
    check("t2_unst_c1", 32'(unst_d), 32'd0);
    step(1'b1, 1'b0, 32'h0000_3004, 1'b0, 2'b00, 1'b0, ST_OK);
    check("t2_unst_c2", 32'(unst_d), 32'd0);
    step(1'b1, 1'b0, 32'h0000_3004, 1'b0, 2'b00, 1'b0, ST_OK);
    check("t2_unst_c3", 32'(unst_d), 32'd1);
    grant(32'h0000_3004);
    respond();
    check("t2_addr", rsp_addr_d, 32'h0000_3004);
    idle();

    // Fill, legal grant-with-pop at full, then overflowing grant
    for (int i = 0; i < 4; i++) grant(32'h0000_4000 + 32'(4 * i));
    step(1'b1, 1'b1, 32'h0000_4010, 1'b0, 2'b00, 1'b1, ST_OK);
    check("t3_full_out", 32'(outst_d), 32'd4);
    check("t3_full_rsp", rsp_addr_d, 32'h0000_4000);
    grant(32'h0000_4014);
    check("t3_over_pre", 32'(over_d), 32'd0);
    idle();
    check("t3_over", 32'(over_d), 32'd1);
    check("t3_over_out", 32'(outst_d), 32'd4);
    drain_exp[0] = 32'h0000_4004; drain_exp[1] = 32'h0000_4008;
    drain_exp[2] = 32'h0000_400C; drain_exp[3] = 32'h0000_4010;
    for (int i = 0; i < 4; i++) begin
      respond();
      check("t3_drain", rsp_addr_d, drain_exp[i]);
    end
    idle();
    check("t3_empty", 32'(outst_d), 32'd0);

    // rvalid with nothing outstanding, grant same cycle
    step(1'b1, 1'b1, 32'h0000_5000, 1'b0, 2'b00, 1'b1, ST_OK);
    check("t4_rsp_valid", 32'(rsp_valid_d), 32'd0);
    idle();
    check("t4_under", 32'(under_d), 32'd1);
    check("t4_out", 32'(outst_d), 32'd1);
    respond();
    check("t4_addr", rsp_addr_d, 32'h0000_5000);
    idle();

    // Attribute checks
    step(1'b1, 1'b1, 32'h0000_7000, 1'b0, 2'b00, 1'b0, ST_BUF);
    step(1'b1, 1'b1, 32'h0000_7004, 1'b1, 2'b00, 1'b0, ST_OK);
    idle();
    check("t5_memtype", 32'(mem_d), 32'd1);
    check("t5_deny_d_we", 32'(deny_d), 32'd0);
    check("t5_deny_i_we", 32'(deny_i), 32'd1);
    step(1'b1, 1'b1, 32'h0000_7008, 1'b0, 2'b00, 1'b0, ST_DENY);
    idle();
    check("t5_deny_d", 32'(deny_d), 32'd1);
    respond();
    check("t5_status0", 32'(rsp_status_d), 32'hE);
    respond();
    check("t5_we1", 32'(rsp_we_d), 32'd1);
    respond();
    check("t5_status2", 32'(rsp_status_d), 32'h4);
    idle();

    // Mid-cycle reset with transactions in flight
    grant(32'h0000_6000);
    grant(32'h0000_6004);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_out_d", 32'(outst_d), 32'd0);
    check("t6_rst_out_i", 32'(outst_i), 32'd0);
    check("t6_rst_flags_d", 32'({unst_d, over_d, under_d, mem_d, deny_d}), 32'd0);
    check("t6_rst_flags_i", 32'({unst_i, over_i, under_i, mem_i, deny_i}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    respond();
    check("t6_rsp_valid", 32'(rsp_valid_d), 32'd0);
    idle();
    check("t6_under", 32'(under_d), 32'd1);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
